ahb_slave_mem: RTL

//  AHB responder with word-organised on-chip memory; the slave-side partner of master_ahb.

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/ahb_slave_ram.sv | 37 +++
 rtl/ahb_slave_mem.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : AHB encodings, slave FSM state type and byte-lane helpers.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DATA = 3'd1,
      ST_ERR1 = 3'd2,
      ST_ERR2 = 3'd3,
      ST_WAIT = 3'd4
   } state_t;

   function automatic logic is_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction

   // Little-endian lane select; callers guarantee size/offset are legal.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
      case (size)
         HSIZE_BYTE: lane_mask = 4'b0001 << offset;
         HSIZE_HALF: lane_mask = 4'b0011 << offset;
         default:    lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_expand(input logic [3:0] mask);
      for (int i = 0; i < 4; i++) begin
         lane_expand[8*i +: 8] = {8{mask[i]}};
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_ram
// Brief    : DEPTH x 32 RAM, byte-enabled write port, synchronous read port
//            with write-first forwarding on same-address collision.
// Revision : 1.0
// ============================================================================
module ahb_slave_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) begin
            mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
         if (re) begin
            rdata[8*b +: 8] <= (we && be[b] && (waddr == raddr)) ? wdata[8*b +: 8]
                                                                 : mem[raddr][8*b +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mem
// Brief    : Pipelined AHB slave over word-organised RAM with ERROR response.
//            Optional macro WAIT_STATE_EN adds WAIT_CYCLES wait states per NONSEQ.
// Revision : 1.0
// ============================================================================
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int          MEM_DEPTH   = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        CLK_SLAVE,
   input  logic        RESET_SLAVE,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HWDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int AW = $clog2(MEM_DEPTH);
`ifdef WAIT_STATE_EN
   localparam logic WAIT_EN = 1'b1;
`else
   localparam logic WAIT_EN = 1'b0;
`endif
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

   state_t        state;
   logic [3:0]    wait_cnt;
   logic [AW-1:0] idx_q;
   logic [3:0]    lanes_q;
   logic          wr_q;
   logic [31:0]   hold_q;
   logic [31:0]   ram_rdata;
   logic [31:0]   rd_masked;
   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          out_of_range;
   logic          misaligned;
   logic          illegal;
   logic          accept;
   logic          rd_phase;
   logic          unused_ok;

   // Burst type is informational; every beat carries its own address.
   assign unused_ok = ^HBURST;

   // Unsigned subtraction folds HADDR < BASE_ADDR into the range check.
   assign offset       = HADDR - BASE_ADDR;
   assign idx          = offset[AW+1:2];
   assign out_of_range = (offset >> (AW + 2)) != 32'd0;
   assign misaligned   = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                         ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
   assign illegal      = (HSIZE > HSIZE_WORD) || misaligned || out_of_range;
   assign accept       = HSEL && HREADY && is_active(HTRANS) && (state != ST_ERR2);

   assign rd_phase  = (state == ST_DATA) && !wr_q;
   assign rd_masked = ram_rdata & lane_expand(lanes_q);
   assign HRDATA    = rd_phase ? rd_masked : hold_q;

   ahb_slave_ram #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLK_SLAVE),
      .we    ((state == ST_DATA) && wr_q),
      .waddr (idx_q),
      .be    (lanes_q),
      .wdata (HWDATA),
      .re    (accept && !HWRITE && !illegal),
      .raddr (idx),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CLK_SLAVE or negedge RESET_SLAVE) begin
      if (!RESET_SLAVE) begin
         state    <= ST_IDLE;
         HREADY   <= 1'b1;
         HRESP    <= HRESP_OKAY;
         wait_cnt <= '0;
         idx_q    <= '0;
         lanes_q  <= '0;
         wr_q     <= 1'b0;
         hold_q   <= '0;
      end else begin
         if (rd_phase) begin
            hold_q <= rd_masked;
         end
         if (accept) begin
            idx_q   <= idx;
            lanes_q <= lane_mask(HSIZE, HADDR[1:0]);
            wr_q    <= HWRITE;
         end
         case (state)
            ST_IDLE, ST_DATA: begin
               if (accept && illegal) begin
                  state  <= ST_ERR1;
                  HREADY <= 1'b0;
                  HRESP  <= HRESP_ERROR;
               end else if (accept && WAIT_EN && (HTRANS == HTRANS_NONSEQ)) begin
                  state    <= ST_WAIT;
                  wait_cnt <= WAIT_INIT;
                  HREADY   <= 1'b0;
                  HRESP    <= HRESP_OKAY;
               end else if (accept) begin
                  state  <= ST_DATA;
                  HREADY <= 1'b1;
                  HRESP  <= HRESP_OKAY;
               end else begin
                  state  <= ST_IDLE;
                  HREADY <= 1'b1;
                  HRESP  <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state  <= ST_DATA;
                  HREADY <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state  <= ST_ERR2;
               HREADY <= 1'b1;
               HRESP  <= HRESP_ERROR;
            end
            default: begin
               // ERR2: the address phase the master presents here is cancelled.
               state  <= ST_IDLE;
               HREADY <= 1'b1;
               HRESP  <= HRESP_OKAY;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
